// File: rtl/ex_mem_arbiter.sv
// ============================================================================
// Module      : ex_mem_arbiter
// Description : Execution-stage rib master arbiter. The core port has fixed
//               priority; accelerator ports rotate round-robin, with burst lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_LOCK = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      lock_i,
  input  logic [NUM_REQ-1:0]      we_i,
  input  logic [32*NUM_REQ-1:0]   addr_i,
  input  logic [32*NUM_REQ-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      ack_o,
  output logic [31:0]             rdata_o,
  output logic                    rib_req_o,
  output logic                    rib_we_o,
  output logic [31:0]             rib_addr_o,
  output logic [31:0]             rib_data_o,
  input  logic [31:0]             rib_data_i,
  input  logic                    rib_hold_i,
  output logic                    hold_core_o
);

  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 sel_req;
  logic                 sel_we;
  logic                 sel_lock;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic [IW-1:0]        rr_rel;
  logic                 release_w;

  // Fixed priority for port 0, then search ports 1..NUM_REQ-1 starting at ptr.
  function automatic logic [NUM_REQ-1:0] arbitrate(input logic [NUM_REQ-1:0] req,
                                                   input logic [IW-1:0]      ptr);
    logic [NUM_REQ-1:0] win;
    logic               found;
    int                 idx;
    win   = '0;
    found = 1'b0;
    if (req[0]) begin
      win[0] = 1'b1;
    end else begin
      for (int j = 0; j < NUM_REQ - 1; j++) begin
        idx = int'(ptr) + j;
        if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

  always_comb begin
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        sel_req   = req_i[k];
        sel_we    = we_i[k];
        sel_lock  = lock_i[k];
        sel_addr  = addr_i[32*k +: 32];
        sel_wdata = wdata_i[32*k +: 32];
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign ack_o       = gnt_q & req_i & {NUM_REQ{~rib_hold_i}};
  assign rib_req_o   = sel_req;
  assign rib_we_o    = sel_we;
  assign rib_addr_o  = sel_addr;
  assign rib_data_o  = sel_wdata;
  assign rdata_o     = ((|ack_o) && !sel_we) ? rib_data_i : 32'd0;
  assign hold_core_o = ~rst & req_i[0] & ~ack_o[0];

  always_comb begin
    rr_rel = rr_q;
    for (int k = 1; k < NUM_REQ; k++) begin
      if (gnt_q[k]) rr_rel = (k == NUM_REQ - 1) ? IW'(1) : IW'(k + 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    release_w = 1'b0;

    case (state_q)
      S_IDLE: release_w = 1'b1;
      S_OWN, S_LOCK: begin
        if (!sel_req) begin
          release_w = 1'b1;
        end else if (!rib_hold_i) begin
          // A waiting core request preempts an accelerator burst at its next ack.
          if (!sel_lock || (int'(cnt_q) + 1 >= MAX_LOCK) || (req_i[0] && !gnt_q[0])) begin
            release_w = 1'b1;
          end else begin
            state_d = S_LOCK;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: release_w = 1'b1;
    endcase

    if (release_w) begin
      rr_d    = rr_rel;
      gnt_d   = arbitrate(req_i, rr_rel);
      cnt_d   = '0;
      state_d = (|gnt_d) ? S_OWN : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= IW'(1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_arbiter.sv
// ============================================================================
// Module      : tb_ex_mem_arbiter
// Description : Directed and randomized bench for ex_mem_arbiter with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ex_mem_arbiter;

  localparam int N  = 4;
  localparam int ML = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, lock, we;
  logic [32*N-1:0] addr, wdata;
  logic [N-1:0]    gnt, ack;
  logic [31:0]     rdata, rib_addr, rib_wdata, rib_rdata;
  logic            rib_req, rib_we, rib_hold, hold_core;

  always #5 clk = ~clk;

  ex_mem_arbiter #(.NUM_REQ(N), .MAX_LOCK(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .lock_i     (lock),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .ack_o      (ack),
    .rdata_o    (rdata),
    .rib_req_o  (rib_req),
    .rib_we_o   (rib_we),
    .rib_addr_o (rib_addr),
    .rib_data_o (rib_wdata),
    .rib_data_i (rib_rdata),
    .rib_hold_i (rib_hold),
    .hold_core_o(hold_core)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current owner (-1 = none), rotation start, acks in burst.
  int m_owner;
  int m_rr;
  int m_cnt;

  logic [N-1:0] e_gnt, e_ack;
  logic [31:0]  e_rdata, e_addr, e_data;
  logic         e_req, e_we, e_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    if (r[0]) return 0;
    for (int j = 0; j < N - 1; j++) begin
      int p;
      p = (ptr - 1 + j) % (N - 1) + 1;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_comb();
    e_gnt = '0; e_ack = '0; e_req = 1'b0; e_we = 1'b0;
    e_addr = '0; e_data = '0; e_rdata = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_req  = req[m_owner];
      e_we   = we[m_owner];
      e_addr = addr[32*m_owner +: 32];
      e_data = wdata[32*m_owner +: 32];
      if (e_req && !rib_hold) begin
        e_ack[m_owner] = 1'b1;
        if (!e_we) e_rdata = rib_rdata;
      end
    end
    e_hold = !rst && req[0] && !e_ack[0];
  endtask

  task automatic model_seq();
    bit rel;
    if (rst) begin
      m_owner = -1; m_rr = 1; m_cnt = 0;
      return;
    end
    rel = 1'b0;
    if (m_owner < 0) rel = 1'b1;
    else if (!req[m_owner]) rel = 1'b1;
    else if (!rib_hold) begin
      if (!lock[m_owner]) rel = 1'b1;
      else begin
        m_cnt++;
        rel = (m_cnt >= ML) || (m_owner != 0 && req[0]);
      end
    end
    if (rel) begin
      if (m_owner >= 1) m_rr = m_owner % (N - 1) + 1;
      m_owner = pick(req, m_rr);
      m_cnt   = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_comb();
    chk("gnt",       32'(gnt),       32'(e_gnt));
    chk("ack",       32'(ack),       32'(e_ack));
    chk("rdata",     rdata,          e_rdata);
    chk("rib_req",   32'(rib_req),   32'(e_req));
    chk("rib_we",    32'(rib_we),    32'(e_we));
    chk("rib_addr",  rib_addr,       e_addr);
    chk("rib_data",  rib_wdata,      e_data);
    chk("hold_core", 32'(hold_core), 32'(e_hold));
  endtask

  task automatic advance();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [N-1:0] order [5];
    bit           pend  [N];
    int           acks1;
    bit           seen3;

    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    rib_rdata = '0; rib_hold = 1'b0;

    // Reset state, with core requesting to show hold_core_o masked in reset
    @(posedge clk); model_seq(); #1;
    req = 4'b0001;
    sample(); chk("rst_hold_core", 32'(hold_core), 32'd0); chk("rst_gnt", 32'(gnt), 32'd0);
    advance();

    // Core-only read
    rst = 1'b0; addr[31:0] = 32'h1000_0000; rib_rdata = 32'hCAFE_0001;
    sample(); chk("d1_idle_gnt", 32'(gnt), 32'd0); chk("d1_hold_core", 32'(hold_core), 32'd1);
    advance();
    sample(); chk("d1_gnt", 32'(gnt), 32'd1); chk("d1_ack", 32'(ack), 32'd1);
    chk("d1_rdata", rdata, 32'hCAFE_0001); chk("d1_addr", rib_addr, 32'h1000_0000);
    advance();
    req = '0; sample(); advance(); sample(); advance();

    // Round-robin among accelerators held continuously
    order[0] = 4'b0010; order[1] = 4'b0100; order[2] = 4'b1000;
    order[3] = 4'b0010; order[4] = 4'b0100;
    req = 4'b1110; rib_rdata = 32'h1234_5678;
    sample(); advance();
    for (int i = 0; i < 5; i++) begin
      sample(); chk("d2_ack_order", 32'(ack), 32'(order[i])); advance();
    end
    req = '0; sample(); advance(); sample(); advance();

    // Core preempts after port2 ack, then rotation resumes at port3
    req = 4'b0100;
    sample(); advance();
    req = 4'b1111;
    sample(); chk("d3_p2_ack", 32'(ack), 32'b0100); advance();
    sample(); chk("d3_core_gnt", 32'(gnt), 32'b0001); chk("d3_core_ack", 32'(ack), 32'b0001); advance();
    req = 4'b1110;
    sample(); chk("d3_core_drop_ack", 32'(ack), 32'd0); advance();
    sample(); chk("d3_p3_gnt", 32'(gnt), 32'b1000); advance();
    req = '0; sample(); advance(); sample(); advance();

    // Port1 burst lock with port3 waiting
    req = 4'b0010; lock = 4'b0010;
    sample(); advance();
    req = 4'b1010;
    acks1 = 0; seen3 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (gnt == 4'b1000) begin
        seen3 = 1'b1;
        break;
      end
      if (ack[1]) acks1++;
      advance();
    end
    chk("d4_lock_acks", 32'(acks1), 32'd16);
    chk("d4_p3_after_lock", 32'(seen3), 32'd1);
    advance();
    req = '0; lock = '0; sample(); advance(); sample(); advance();

    // Bus hold during a port2 write
    req = 4'b0100; we = 4'b0100; addr[95:64] = 32'h2000_0008; wdata[95:64] = 32'hDEAD_BEEF;
    sample(); advance();
    rib_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("d5_hold_ack", 32'(ack), 32'd0);
      chk("d5_hold_addr", rib_addr, 32'h2000_0008);
      chk("d5_hold_data", rib_wdata, 32'hDEAD_BEEF);
      advance();
    end
    rib_hold = 1'b0;
    sample(); chk("d5_ack", 32'(ack), 32'b0100); chk("d5_wr_rdata", rdata, 32'd0); advance();
    req = '0; we = '0; sample(); advance(); sample(); advance();

    // Reset in the middle of a port1 lock; rotation pointer is 3 beforehand
    req = 4'b0010; lock = 4'b0010;
    sample(); advance();
    for (int c = 0; c < 3; c++) begin
      sample(); advance();
    end
    rst = 1'b1; req = 4'b0011;
    sample(); chk("d6_hold_in_rst", 32'(hold_core), 32'd0); advance();
    sample(); chk("d6_gnt", 32'(gnt), 32'd0); chk("d6_rib_req", 32'(rib_req), 32'd0);
    chk("d6_hold_core", 32'(hold_core), 32'd0);
    advance();
    rst = 1'b0; req = 4'b1110; lock = '0;
    sample(); advance();
    sample(); chk("d6_rr_reset", 32'(gnt), 32'b0010); advance();
    req = '0; sample(); advance(); sample(); advance();

    // Randomized traffic
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(99) < ((k == 0) ? 12 : 40)) begin
          pend[k] = 1'b1;
          we[k]   = $urandom_range(1) == 1;
          lock[k] = $urandom_range(99) < 30;
          addr[32*k +: 32]  = $urandom;
          wdata[32*k +: 32] = $urandom;
        end else if (pend[k] && $urandom_range(99) < 2) begin
          pend[k] = 1'b0;
        end
        req[k] = pend[k];
      end
      rib_hold  = $urandom_range(99) < 20;
      rib_rdata = $urandom;
      rst       = $urandom_range(999) < 5;
      sample();
      advance();
      for (int k = 0; k < N; k++) begin
        if (e_ack[k]) begin
          pend[k] = $urandom_range(1) == 1;
          if (pend[k]) begin
            we[k]   = $urandom_range(1) == 1;
            lock[k] = $urandom_range(99) < 30;
            addr[32*k +: 32]  = $urandom;
            wdata[32*k +: 32] = $urandom;
          end
          req[k] = pend[k];
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
